timer_counter: RTL

Parametrised successor to the free-running 32-bit cycle counter. Adds the following over the plain counter:
- configurable width
- prescaler
- programmable modulo (terminal value)
- up/down direction
- synchronous load and clear
- one-shot mode with a terminal-count pulse

Used as a general timebase and event timer across the design. Counter state is read directly on COUNTER.

---
 rtl/timer_counter.sv | 68 ++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: prescaled up/down modulo timer with one-shot mode and a terminal-count pulse.
// Defining COUNTER_CAPTURE_EN adds the CAPTURE/CAPTURE_VALUE/CAPTURE_VALID snapshot port.
module timer_counter #(
  parameter int WIDTH = 32,
  parameter int PRESCALE_W = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  CLOCK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [WIDTH-1:0]      LOAD_VALUE,
  input  logic                  UP,
  input  logic [WIDTH-1:0]      MODULO,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  ONESHOT,
`ifdef COUNTER_CAPTURE_EN
  input  logic                  CAPTURE,
  output logic [WIDTH-1:0]      CAPTURE_VALUE,
  output logic                  CAPTURE_VALID,
`endif
  output logic [WIDTH-1:0]      COUNTER,
  output logic                  TC,
  output logic                  RUNNING
);
  localparam logic [WIDTH-1:0] one = 1;
  localparam logic [PRESCALE_W-1:0] pre_one = 1;
  logic [PRESCALE_W-1:0] pre, pre_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic tick, term, rearm, tc_nxt, run_nxt;
  always_comb begin
    rearm = CLR | LOAD;
    tick = EN & RUNNING & (pre == PRESCALE);
    term = tick & (UP ? (COUNTER == MODULO) : (COUNTER == '0));
    // a one-shot terminal event freezes COUNTER at its terminal value instead of wrapping
    cnt_nxt = CLR ? '0 :
              LOAD ? LOAD_VALUE :
              !tick ? COUNTER :
              term ? (ONESHOT ? COUNTER : (UP ? '0 : MODULO)) :
              UP ? COUNTER + one : COUNTER - one;
    pre_nxt = rearm ? '0 : !(EN & RUNNING) ? pre : tick ? '0 : pre + pre_one;
    tc_nxt = !rearm & term;
    run_nxt = rearm ? 1'b1 : (term & ONESHOT) ? 1'b0 : RUNNING;
  end
  always_ff @(posedge CLOCK or negedge RST)
    if (!RST) begin
      COUNTER <= RESET_VALUE;
      pre <= '0;
      TC <= 1'b0;
      RUNNING <= 1'b1;
    end else begin
      COUNTER <= cnt_nxt;
      pre <= pre_nxt;
      TC <= tc_nxt;
      RUNNING <= run_nxt;
    end
`ifdef COUNTER_CAPTURE_EN
  always_ff @(posedge CLOCK or negedge RST)
    if (!RST) begin
      CAPTURE_VALUE <= '0;
      CAPTURE_VALID <= 1'b0;
    end else begin
      CAPTURE_VALUE <= CAPTURE ? COUNTER : CAPTURE_VALUE;
      CAPTURE_VALID <= CAPTURE;
    end
`endif
endmodule
